// File: rtl/axis_pkg.sv
// Shared route and state encodings for the packet-aware stream demultiplexer.
package axis_pkg;

   localparam logic ROUTE_0 = 1'b0;
   localparam logic ROUTE_1 = 1'b1;

   typedef enum logic {
      ST_SOP  = 1'b0,
      ST_BODY = 1'b1
   } state_t;

endpackage

// File: rtl/axis_skid.sv
// Two-entry skid buffer: a main output register plus one skid register.
// The input ready is a flop that is high exactly when the skid register is
// empty, so no combinational path runs from out_ready to in_ready.
module axis_skid #(
   parameter int W = 513
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [W-1:0] out_data,
   output logic         out_valid,
   input  logic         out_ready
);

   logic [W-1:0] main_data_q, main_data_d;
   logic         main_valid_q, main_valid_d;
   logic [W-1:0] skid_data_q, skid_data_d;
   logic         skid_valid_q, skid_valid_d;
   logic         ready_q, ready_d;
   logic         in_hs_s;

   // Ready is forced low while reset is asserted; the flop itself resets to
   // "skid empty" so the buffer accepts on the first cycle after reset.
   assign in_ready  = ready_q & ~reset;
   assign out_data  = main_data_q;
   assign out_valid = main_valid_q;

   // Next-state for main/skid registers: refill main from skid first to keep order.
   always_comb begin
      main_data_d  = main_data_q;
      main_valid_d = main_valid_q;
      skid_data_d  = skid_data_q;
      skid_valid_d = skid_valid_q;
      in_hs_s      = in_valid & ready_q;
      if (!main_valid_q || out_ready) begin
         // Main register is free (empty or draining this cycle).
         if (skid_valid_q) begin
            main_data_d  = skid_data_q;
            main_valid_d = 1'b1;
            skid_valid_d = 1'b0;
         end else if (in_hs_s) begin
            main_data_d  = in_data;
            main_valid_d = 1'b1;
         end else begin
            main_valid_d = 1'b0;
         end
      end else begin
         // Main register is stalled; an accepted beat parks in the skid slot.
         if (in_hs_s) begin
            skid_data_d  = in_data;
            skid_valid_d = 1'b1;
         end else begin
            skid_valid_d = skid_valid_q;
         end
      end
      ready_d = ~skid_valid_d;
   end

   // Register update with synchronous reset that empties both slots.
   always_ff @(posedge clk) begin
      if (reset) begin
         main_data_q  <= '0;
         main_valid_q <= 1'b0;
         skid_data_q  <= '0;
         skid_valid_q <= 1'b0;
         ready_q      <= 1'b1;
      end else begin
         main_data_q  <= main_data_d;
         main_valid_q <= main_valid_d;
         skid_data_q  <= skid_data_d;
         skid_valid_q <= skid_valid_d;
         ready_q      <= ready_d;
      end
   end

endmodule

// File: rtl/axis_demux.sv
// Packet-aware 1:2 stream demultiplexer. The route is taken from sel on the
// first beat of a packet and held until tlast; each output is registered
// through its own skid buffer so one blocked output never stalls the other's drain.
module axis_demux
   import axis_pkg::*;
#(
   parameter int DW = 512,
   parameter int CW = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          sel,
   input  logic [DW-1:0] axis_in_tdata,
   input  logic          axis_in_tlast,
   input  logic          axis_in_tvalid,
   output logic          axis_in_tready,
   output logic [DW-1:0] axis0_tdata,
   output logic          axis0_tlast,
   output logic          axis0_tvalid,
   input  logic          axis0_tready,
   output logic [DW-1:0] axis1_tdata,
   output logic          axis1_tlast,
   output logic          axis1_tvalid,
   input  logic          axis1_tready,
   output logic [CW-1:0] pkt_count0,
   output logic [CW-1:0] pkt_count1,
   output logic          in_packet
);

   localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

   state_t        state_q, state_d;
   logic          route_q, route_d;
   logic [CW-1:0] cnt0_q, cnt0_d;
   logic [CW-1:0] cnt1_q, cnt1_d;
   logic          route_s;
   logic          in_hs_s;
   logic          rdy0_s, rdy1_s;
   logic          vld0_s, vld1_s;

   // Current route: live sel at start of packet, latched route inside a packet.
   always_comb begin
      if (state_q == ST_SOP) begin
         route_s = sel;
      end else begin
         route_s = route_q;
      end
   end

   // Steer valid to the routed buffer only and take ready from that buffer.
   always_comb begin
      vld0_s = 1'b0;
      vld1_s = 1'b0;
      if (route_s == ROUTE_1) begin
         vld1_s         = axis_in_tvalid;
         axis_in_tready = rdy1_s;
      end else begin
         vld0_s         = axis_in_tvalid;
         axis_in_tready = rdy0_s;
      end
      in_hs_s = axis_in_tvalid & axis_in_tready;
   end

   // Packet FSM and per-route end-of-packet counters.
   always_comb begin
      state_d = state_q;
      route_d = route_q;
      cnt0_d  = cnt0_q;
      cnt1_d  = cnt1_q;
      case (state_q)
         ST_SOP: begin
            if (in_hs_s && !axis_in_tlast) begin
               state_d = ST_BODY;
               route_d = sel;
            end else begin
               state_d = ST_SOP;
            end
         end
         ST_BODY: begin
            if (in_hs_s && axis_in_tlast) begin
               state_d = ST_SOP;
            end else begin
               state_d = ST_BODY;
            end
         end
         default: begin
            state_d = ST_SOP;
         end
      endcase
      if (in_hs_s && axis_in_tlast) begin
         if (route_s == ROUTE_1) begin
            cnt1_d = cnt1_q + CNT_ONE;
         end else begin
            cnt0_d = cnt0_q + CNT_ONE;
         end
      end else begin
         cnt0_d = cnt0_q;
         cnt1_d = cnt1_q;
      end
   end

   // FSM, latched route and counter registers; reset abandons any open packet.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_SOP;
         route_q <= ROUTE_0;
         cnt0_q  <= '0;
         cnt1_q  <= '0;
      end else begin
         state_q <= state_d;
         route_q <= route_d;
         cnt0_q  <= cnt0_d;
         cnt1_q  <= cnt1_d;
      end
   end

   assign pkt_count0 = cnt0_q;
   assign pkt_count1 = cnt1_q;
   assign in_packet  = (state_q == ST_BODY);

   axis_skid #(.W(DW + 1)) u_skid0 (
      .clk       (clk),
      .reset     (reset),
      .in_data   ({axis_in_tlast, axis_in_tdata}),
      .in_valid  (vld0_s),
      .in_ready  (rdy0_s),
      .out_data  ({axis0_tlast, axis0_tdata}),
      .out_valid (axis0_tvalid),
      .out_ready (axis0_tready)
   );

   axis_skid #(.W(DW + 1)) u_skid1 (
      .clk       (clk),
      .reset     (reset),
      .in_data   ({axis_in_tlast, axis_in_tdata}),
      .in_valid  (vld1_s),
      .in_ready  (rdy1_s),
      .out_data  ({axis1_tlast, axis1_tdata}),
      .out_valid (axis1_tvalid),
      .out_ready (axis1_tready)
   );

endmodule

// File: tb/tb_axis_demux.sv
// Directed bench for axis_demux: inputs change on the falling edge, every
// falling edge compares DUT outputs against per-output scoreboard queues and
// a small packet/route/counter model kept by the bench.
module tb_axis_demux;

   localparam int DW = 32;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          sel;
   logic [DW-1:0] in_data;
   logic          in_last;
   logic          in_valid;
   logic          axis_in_tready;
   logic [DW-1:0] axis0_tdata;
   logic          axis0_tlast;
   logic          axis0_tvalid;
   logic          axis0_tready;
   logic [DW-1:0] axis1_tdata;
   logic          axis1_tlast;
   logic          axis1_tvalid;
   logic          axis1_tready;
   logic [CW-1:0] pkt_count0;
   logic [CW-1:0] pkt_count1;
   logic          in_packet;

   int checks = 0;
   int errors = 0;

   logic [DW:0]   q0[$];
   logic [DW:0]   q1[$];
   logic          m_body;
   logic          m_route;
   logic [CW-1:0] m_cnt0;
   logic [CW-1:0] m_cnt1;
   int            hold0;
   int            hold1;
   logic          acc;

   always #5 clk = ~clk;

   axis_demux #(.DW(DW), .CW(CW)) dut (
      .clk            (clk),
      .reset          (reset),
      .sel            (sel),
      .axis_in_tdata  (in_data),
      .axis_in_tlast  (in_last),
      .axis_in_tvalid (in_valid),
      .axis_in_tready (axis_in_tready),
      .axis0_tdata    (axis0_tdata),
      .axis0_tlast    (axis0_tlast),
      .axis0_tvalid   (axis0_tvalid),
      .axis0_tready   (axis0_tready),
      .axis1_tdata    (axis1_tdata),
      .axis1_tlast    (axis1_tlast),
      .axis1_tvalid   (axis1_tvalid),
      .axis1_tready   (axis1_tready),
      .pkt_count0     (pkt_count0),
      .pkt_count1     (pkt_count1),
      .in_packet      (in_packet)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // One clock: apply downstream readies, compare outputs, record handshakes.
   task automatic tick();
      logic r;
      logic er;
      axis0_tready = (hold0 == 0);
      if (hold0 > 0) hold0--;
      axis1_tready = (hold1 == 0);
      if (hold1 > 0) hold1--;
      if (reset) begin
         axis0_tready = 1'b0;
         axis1_tready = 1'b0;
      end
      #1;
      acc = 1'b0;
      if (reset) begin
         chk("rst_tready", 64'(axis_in_tready), 64'(1'b0));
         q0.delete();
         q1.delete();
         m_body  = 1'b0;
         m_route = 1'b0;
         m_cnt0  = '0;
         m_cnt1  = '0;
      end else begin
         r  = m_body ? m_route : sel;
         er = r ? (q1.size() < 2) : (q0.size() < 2);
         chk("in_tready", 64'(axis_in_tready), 64'(er));
         chk("in_packet", 64'(in_packet), 64'(m_body));
         chk("cnt0", 64'(pkt_count0), 64'(m_cnt0));
         chk("cnt1", 64'(pkt_count1), 64'(m_cnt1));
         chk("out0_valid", 64'(axis0_tvalid), 64'(q0.size() > 0));
         chk("out1_valid", 64'(axis1_tvalid), 64'(q1.size() > 0));
         if (axis0_tvalid && q0.size() > 0) begin
            chk("out0_beat", 64'({axis0_tlast, axis0_tdata}), 64'(q0[0]));
            if (axis0_tready) void'(q0.pop_front());
         end
         if (axis1_tvalid && q1.size() > 0) begin
            chk("out1_beat", 64'({axis1_tlast, axis1_tdata}), 64'(q1[0]));
            if (axis1_tready) void'(q1.pop_front());
         end
         if (in_valid && axis_in_tready) begin
            acc = 1'b1;
            if (r) q1.push_back({in_last, in_data});
            else   q0.push_back({in_last, in_data});
            if (in_last) begin
               if (r) m_cnt1 = m_cnt1 + 4'd1;
               else   m_cnt0 = m_cnt0 + 4'd1;
            end
            if (!m_body && !in_last) begin
               m_body  = 1'b1;
               m_route = sel;
            end else if (m_body && in_last) begin
               m_body = 1'b0;
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic send(input logic s, input logic [DW-1:0] d, input logic l, output int n);
      sel      = s;
      in_data  = d;
      in_last  = l;
      in_valid = 1'b1;
      n        = 0;
      do begin
         tick();
         n++;
      end while (!acc && n < 40);
      chk("accept_timeout", 64'(acc), 64'(1'b1));
   endtask

   task automatic idle(input int cycles);
      in_valid = 1'b0;
      repeat (cycles) tick();
   endtask

   initial begin
      int n;
      int tot;
      logic s;
      reset        = 1'b1;
      sel          = 1'b0;
      in_data      = '0;
      in_last      = 1'b0;
      in_valid     = 1'b0;
      hold0        = 0;
      hold1        = 0;
      axis0_tready = 1'b1;
      axis1_tready = 1'b1;
      @(negedge clk);
      tick();
      reset = 1'b0;
      chk("rst_v0", 64'(axis0_tvalid), 64'(1'b0));
      chk("rst_v1", 64'(axis1_tvalid), 64'(1'b0));
      chk("rst_d0", 64'({axis0_tlast, axis0_tdata}), 64'(0));
      chk("rst_d1", 64'({axis1_tlast, axis1_tdata}), 64'(0));
      chk("rst_cnt0", 64'(pkt_count0), 64'(0));
      chk("rst_cnt1", 64'(pkt_count1), 64'(0));
      chk("rst_inpkt", 64'(in_packet), 64'(1'b0));

      // single-beat packets alternating routes, full rate
      tot = 0;
      for (int i = 0; i < 4; i++) begin
         send(1'(i % 2), 32'hA0 + 32'(i), 1'b1, n);
         tot += n;
      end
      chk("t1_rate", 64'(tot), 64'(4));
      chk("t1_cnt0", 64'(pkt_count0), 64'(2));
      chk("t1_cnt1", 64'(pkt_count1), 64'(2));
      idle(3);

      // 8-beat packet, sel toggling after the first beat
      tot = 0;
      s   = 1'b0;
      for (int j = 0; j < 8; j++) begin
         send(s, 32'hB0 + 32'(j), (j == 7), n);
         tot += n;
         s = ~s;
      end
      chk("t2_rate", 64'(tot), 64'(8));
      idle(3);
      chk("t2_cnt0", 64'(pkt_count0), 64'(3));
      chk("t2_cnt1", 64'(pkt_count1), 64'(2));

      // axis0 backpressure for 5 cycles mid-packet
      for (int j = 0; j < 8; j++) begin
         if (j == 3) hold0 = 5;
         send(1'b0, 32'hC0 + 32'(j), (j == 7), n);
      end
      idle(4);
      chk("t3_cnt0", 64'(pkt_count0), 64'(4));

      // axis0 holds 2 beats while an axis1 packet streams through
      hold0 = 14;
      send(1'b0, 32'hD0, 1'b0, n);
      send(1'b0, 32'hD1, 1'b1, n);
      tot = 0;
      for (int j = 0; j < 4; j++) begin
         send(1'b1, 32'hE0 + 32'(j), (j == 3), n);
         tot += n;
      end
      chk("t4_rate", 64'(tot), 64'(4));
      chk("t4_held_v", 64'(axis0_tvalid), 64'(1'b1));
      chk("t4_held_d", 64'({axis0_tlast, axis0_tdata}), 64'({1'b0, 32'hD0}));
      idle(14);
      chk("t4_cnt0", 64'(pkt_count0), 64'(5));
      chk("t4_cnt1", 64'(pkt_count1), 64'(3));

      // reset on beat 3 of a 6-beat packet to axis1
      send(1'b1, 32'hF0, 1'b0, n);
      send(1'b0, 32'hF1, 1'b0, n);
      sel      = 1'b0;
      in_data  = 32'hF2;
      in_last  = 1'b0;
      in_valid = 1'b1;
      reset    = 1'b1;
      tick();
      reset    = 1'b0;
      in_valid = 1'b0;
      chk("t5_v0", 64'(axis0_tvalid), 64'(1'b0));
      chk("t5_v1", 64'(axis1_tvalid), 64'(1'b0));
      chk("t5_cnt0", 64'(pkt_count0), 64'(0));
      chk("t5_cnt1", 64'(pkt_count1), 64'(0));
      chk("t5_inpkt", 64'(in_packet), 64'(1'b0));
      send(1'b0, 32'h55, 1'b1, n);
      idle(2);
      chk("t5_cnt0b", 64'(pkt_count0), 64'(1));
      chk("t5_cnt1b", 64'(pkt_count1), 64'(0));

      // 16 packets to axis0 wrap the 4-bit counter
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 15; i++) begin
         send(1'b0, 32'h100 + 32'(i), 1'b1, n);
      end
      chk("t6_cnt15", 64'(pkt_count0), 64'(15));
      send(1'b0, 32'h10F, 1'b1, n);
      chk("t6_wrap", 64'(pkt_count0), 64'(0));
      idle(3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/axis_demux.md
Name: axis_demux

Overview:
- Packet-aware 1:2 AXI-stream demultiplexer; the transmit-side counterpart of the 2:1 stream mux in the buffer path.
- Steers each complete packet from one input stream to output 0 or 1.
- The route is chosen by a select input sampled on the first beat of each packet and held until tlast.
- Both outputs are registered through skid buffers, giving full throughput with no combinational ready path from output to input.

Parameters:
- DW, 512, tdata width in bits.
- CW, 32, width of the per-output packet counters.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- sel  input  1  route for next packet (0 -> axis0, 1 -> axis1); sampled only at start-of-packet handshake.
- axis_in_tdata  input  DW  input data.
- axis_in_tlast  input  1  last beat of packet.
- axis_in_tvalid  input  1  input valid.
- axis_in_tready  output  1  input ready.
- axis0_tdata  output  DW  output 0 data.
- axis0_tlast  output  1  output 0 last.
- axis0_tvalid  output  1  output 0 valid.
- axis0_tready  input  1  output 0 ready.
- axis1_tdata / axis1_tlast / axis1_tvalid / axis1_tready: same as axis0, for output 1.
- pkt_count0  output  CW  packets fully accepted toward output 0.
- pkt_count1  output  CW  packets fully accepted toward output 1.
- in_packet  output  1  high between first and last accepted beat of a multi-beat packet.

Behaviour:
- Reset (sync, active-high, dominant over all other inputs):
  - all tvalid outputs = 0; tdata = 0; tlast = 0.
  - pkt_count0/1 = 0; in_packet = 0; FSM = SOP.
  - both skid buffers empty; axis_in_tready = 0 during the reset cycle.
- FSM states:
  - SOP: next accepted beat is the first beat of a packet. Route comes combinationally from sel.
  - BODY: route comes from the registered route latched at SOP; sel is ignored.
- FSM transitions:
  - SOP, handshake with tlast = 0 -> BODY; latch route <= sel.
  - SOP, handshake with tlast = 1 (single-beat packet) -> stay in SOP; counter increments.
  - BODY, handshake with tlast = 1 -> SOP.
  - No handshake -> no state change.
- Handshakes:
  - axis_in_tready = input-side ready of the skid buffer of the current route (sel in SOP, latched route in BODY).
  - The non-selected output sees no beat.
  - sel may change while tvalid is high in SOP; the value present on the handshake cycle wins.
- Latency: 1 cycle from input handshake to the beat appearing on the output.
- Throughput: 1 beat/clk sustained while the downstream ready is held high.
- Skid buffer (per output):
  - Main register plus one skid register.
  - Input ready is registered and equals "skid register empty".
  - Beats are never dropped or duplicated, and order is preserved.
  - tdata/tlast are stable while tvalid is high and tready is low.
- Backpressure on one output does not stall the other output's drain; queued beats on the free output continue to emit.
- Counters:
  - Increment on input handshake with tlast = 1, on the counter for the route of that beat.
  - Wrap modulo 2^CW.
- in_packet is 1 exactly when the FSM is in BODY.
- Reset mid-packet: FSM returns to SOP and buffered beats are discarded. The partial packet is not counted; the downstream consumer is responsible for its own reset.

Decomposition:
- Shared package axis_pkg: localparams ROUTE_0 = 1'b0, ROUTE_1 = 1'b1, and state encodings ST_SOP / ST_BODY.
- Sub-module axis_skid (DW+1 bits wide, carrying tdata and tlast), instantiated once per output.
- FSM, routing and counters live in axis_demux.

Test Plan:
- Single-beat packets, sel alternating 0,1,0,1, both treadys = 1 -> 0xA0 and 0xA2 appear on axis0, 0xA1 and 0xA3 on axis1, each 1 cycle after acceptance; pkt_count0 = 2, pkt_count1 = 2.
- 8-beat packet with sel = 0 at SOP, sel toggled every cycle thereafter -> all 8 beats on axis0, axis1_tvalid never asserts, in_packet high for beats 1-7.
- axis0_tready = 0 for 5 cycles mid-packet -> axis_in_tready drops after at most 2 beats are buffered; no loss or reorder; data is held stable on axis0.
- Packet to axis1 while axis0 holds 2 backpressured beats -> the axis1 packet flows at 1 beat/clk, and the axis0 beats are released intact when tready returns.
- Reset asserted on beat 3 of a 6-beat packet -> next cycle all tvalid = 0, counters = 0, in_packet = 0; the following packet routes by its own sel.
- pkt_count0 preloaded by driving 2^CW packets with CW = 4 -> 16 packets to axis0 wrap the count to 0.
